// File: rtl/memref_mp_model.sv
// Multi-port behavioural memory for testbenches: NWR writers, NRD readers, fixed read latency,
// selectable read-during-write result, sticky protocol-error flags and saturating access counters.
module memref_mp_model #(
  parameter int WIDTH      = 32,
  parameter int SIZE       = 8,
  parameter int NWR        = 1,
  parameter int NRD        = 2,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0,
  parameter int CNT_W      = 16,
  localparam int AW        = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_data,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_valid,
  output logic                 err_wr_conflict,
  output logic                 err_oob,
  output logic [CNT_W-1:0]     wr_count,
  output logic [CNT_W-1:0]     rd_count
);

  localparam logic [AW:0]      SIZE_A  = (AW+1)'(SIZE);
  localparam int               SUM_W   = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] mem [SIZE];

  logic [AW-1:0]    wa   [NWR];
  logic [WIDTH-1:0] wd   [NWR];
  logic [NWR-1:0]   wok;
  logic [NWR-1:0]   wacc;
  logic [AW-1:0]    ra   [NRD];
  logic [NRD-1:0]   rok;
  logic [NRD-1:0]   racc;
  logic [WIDTH-1:0] samp [NRD];
  logic             conflict;
  logic             oob;
  logic [2:0]       n_wr;
  logic [2:0]       n_rd;
  logic [SUM_W-1:0] wr_sum;
  logic [SUM_W-1:0] rd_sum;

  logic [NRD-1:0]   vpipe [RD_LATENCY];
  logic [WIDTH-1:0] dpipe [RD_LATENCY][NRD];

  always_comb begin
    for (int i = 0; i < NWR; i++) begin
      wa[i]   = wr_addr[i*AW +: AW];
      wd[i]   = wr_data[i*WIDTH +: WIDTH];
      wok[i]  = ({1'b0, wa[i]} < SIZE_A);
      wacc[i] = wr_en[i] & wok[i];
    end
    for (int j = 0; j < NRD; j++) begin
      ra[j]   = rd_addr[j*AW +: AW];
      rok[j]  = ({1'b0, ra[j]} < SIZE_A);
      racc[j] = rd_en[j] & rok[j];
    end
  end

  always_comb begin
    conflict = 1'b0;
    n_wr     = 3'd0;
    n_rd     = 3'd0;
    oob      = (|(wr_en & ~wok)) | (|(rd_en & ~rok));
    for (int i = 0; i < NWR; i++) begin
      if (wacc[i]) n_wr = n_wr + 3'd1;
      for (int k = i + 1; k < NWR; k++) begin
        if (wacc[i] && wacc[k] && (wa[i] == wa[k])) conflict = 1'b1;
      end
    end
    for (int j = 0; j < NRD; j++) begin
      if (racc[j]) n_rd = n_rd + 3'd1;
    end
    wr_sum = SUM_W'(wr_count) + SUM_W'(n_wr);
    rd_sum = SUM_W'(rd_count) + SUM_W'(n_rd);
  end

  // Ascending port order lets the highest-index writer win, matching the array update below.
  always_comb begin
    for (int j = 0; j < NRD; j++) begin
      samp[j] = {WIDTH{1'bx}};
      if (rok[j]) begin
        samp[j] = mem[ra[j]];
        if (RDW_MODE != 0) begin
          for (int i = 0; i < NWR; i++) begin
            if (wacc[i] && (wa[i] == ra[j])) samp[j] = wd[i];
          end
        end
      end
    end
  end

  // Contents survive reset; only the access side is held off while rst_n is low.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NWR; i++) begin
        if (wacc[i]) mem[wa[i]] <= wd[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        vpipe[s] <= '0;
        for (int j = 0; j < NRD; j++) dpipe[s][j] <= '0;
      end
    end else begin
      vpipe[0] <= rd_en;
      for (int j = 0; j < NRD; j++) begin
        dpipe[0][j] <= rd_en[j] ? samp[j] : {WIDTH{1'bx}};
      end
      for (int s = 1; s < RD_LATENCY; s++) begin
        vpipe[s] <= vpipe[s-1];
        for (int j = 0; j < NRD; j++) dpipe[s][j] <= dpipe[s-1][j];
      end
    end
  end

  always_comb begin
    rd_valid = vpipe[RD_LATENCY-1];
    for (int j = 0; j < NRD; j++) begin
      rd_data[j*WIDTH +: WIDTH] = dpipe[RD_LATENCY-1][j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_wr_conflict <= 1'b0;
      err_oob         <= 1'b0;
      wr_count        <= '0;
      rd_count        <= '0;
    end else begin
      if (conflict) err_wr_conflict <= 1'b1;
      if (oob)      err_oob         <= 1'b1;
      wr_count <= (wr_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : wr_sum[CNT_W-1:0];
      rd_count <= (rd_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : rd_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_memref_mp_model.sv
// Two memories share one stimulus stream: dut0 (latency 2, old-data RDW, 16-bit counters)
// and dut1 (latency 1, new-data RDW, 3-bit counters), both 2W/2R with SIZE=6.
module tb_memref_mp_model;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wr_en, rd_en;
  logic [5:0]  wr_addr, rd_addr;
  logic [63:0] wr_data;
  logic [63:0] rd_data0, rd_data1;
  logic [1:0]  rd_valid0, rd_valid1;
  logic        ewc0, ewc1, eoob0, eoob1;
  logic [15:0] wc0, rc0;
  logic [2:0]  wc1, rc1;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct { int due; bit chk; logic [31:0] d; } rexp_t;
  typedef struct { int due; bit rst; int wc; int rc; bit ewc; bit eoob; } cexp_t;

  rexp_t       rq [4][$];
  cexp_t       cq [2][$];
  logic [31:0] mmem [6];
  bit          mknown [6];
  int          mwc, mrc;
  bit          mewc, meoob;

  memref_mp_model #(.WIDTH(32), .SIZE(6), .NWR(2), .NRD(2), .RD_LATENCY(2), .RDW_MODE(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .err_wr_conflict(ewc0), .err_oob(eoob0), .wr_count(wc0), .rd_count(rc0));

  memref_mp_model #(.WIDTH(32), .SIZE(6), .NWR(2), .NRD(2), .RD_LATENCY(1), .RDW_MODE(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .err_wr_conflict(ewc1), .err_oob(eoob1), .wr_count(wc1), .rd_count(rc1));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int lat(int d);  return (d == 0) ? 2 : 1;     endfunction
  function automatic int cmax(int d); return (d == 0) ? 65535 : 7; endfunction
  function automatic bit rdw_new(int d); return d == 1;            endfunction
  function automatic int sat(int v, int m); return (v > m) ? m : v; endfunction

  task automatic check(string name, int d, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d: got %0h, expected %0h", name, d, cyc, act, exp);
    end
  endtask

  // Monitor: runs on the falling edge, pops whatever the DUT presents.
  task automatic mon(int d, logic [1:0] v, logic [63:0] data, int wc, int rc, logic ewc, logic eoob);
    rexp_t e;
    cexp_t c;
    for (int p = 0; p < 2; p++) begin
      int q;
      q = d * 2 + p;
      while (rq[q].size() > 0 && rq[q][0].due < cyc) begin
        check("rd_valid_missing", d, 64'd0, 64'd1);
        void'(rq[q].pop_front());
      end
      if (v[p]) begin
        if (rq[q].size() == 0) check("rd_valid_unexpected", d, 64'd1, 64'd0);
        else begin
          e = rq[q].pop_front();
          check("rd_latency", d, 64'(cyc), 64'(e.due));
          if (e.chk) check("rd_data", d, 64'(data[p*32 +: 32]), 64'(e.d));
        end
      end
    end
    while (cq[d].size() > 0 && cq[d][0].due < cyc) begin
      check("status_missed", d, 64'd0, 64'd1);
      void'(cq[d].pop_front());
    end
    if (cq[d].size() > 0 && cq[d][0].due == cyc) begin
      c = cq[d].pop_front();
      check("wr_count", d, 64'(wc), 64'(c.wc));
      check("rd_count", d, 64'(rc), 64'(c.rc));
      check("err_wr_conflict", d, 64'(ewc), 64'(c.ewc));
      check("err_oob", d, 64'(eoob), 64'(c.eoob));
      if (c.rst) begin
        check("rst_rd_valid", d, 64'(v), 64'd0);
        check("rst_rd_data", d, data, 64'd0);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, rd_valid0, rd_data0, 32'(wc0), 32'(rc0), ewc0, eoob0);
    mon(1, rd_valid1, rd_data1, 32'(wc1), 32'(rc1), ewc1, eoob1);
  end

  // Called #1 after a rising edge; drives the next edge and records what it should produce.
  task automatic step(logic [1:0] we, int wa0, int wa1, logic [31:0] wd0, logic [31:0] wd1,
                      logic [1:0] re, int ra0, int ra1);
    int          wa [2];
    int          ra [2];
    logic [31:0] wd [2];
    bit          wv [6];
    logic [31:0] wvd [6];
    int          nw, nr;
    rexp_t       e;
    cexp_t       c;
    wa[0] = wa0; wa[1] = wa1; ra[0] = ra0; ra[1] = ra1; wd[0] = wd0; wd[1] = wd1;
    wr_en = we; wr_addr = {3'(wa1), 3'(wa0)}; wr_data = {wd1, wd0};
    rd_en = re; rd_addr = {3'(ra1), 3'(ra0)};
    nw = 0; nr = 0;
    for (int w = 0; w < 6; w++) begin wv[w] = 1'b0; wvd[w] = '0; end
    for (int i = 0; i < 2; i++) begin
      if (we[i]) begin
        if (wa[i] < 6) begin nw++; wv[wa[i]] = 1'b1; wvd[wa[i]] = wd[i]; end
        else meoob = 1'b1;
      end
    end
    if (we == 2'b11 && wa0 == wa1 && wa0 < 6) mewc = 1'b1;
    for (int j = 0; j < 2; j++) begin
      if (re[j]) begin
        if (ra[j] < 6) nr++;
        else meoob = 1'b1;
      end
    end
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < 2; j++) begin
        if (re[j]) begin
          e.due = cyc + lat(d);
          e.chk = 1'b0;
          e.d   = '0;
          if (ra[j] < 6) begin
            if (rdw_new(d) && wv[ra[j]]) begin e.chk = 1'b1; e.d = wvd[ra[j]]; end
            else begin e.chk = mknown[ra[j]]; e.d = mmem[ra[j]]; end
          end
          rq[d*2+j].push_back(e);
        end
      end
    end
    for (int w = 0; w < 6; w++) begin
      if (wv[w]) begin mmem[w] = wvd[w]; mknown[w] = 1'b1; end
    end
    mwc += nw;
    mrc += nr;
    for (int d = 0; d < 2; d++) begin
      c.due = cyc + 1; c.rst = 1'b0;
      c.wc = sat(mwc, cmax(d)); c.rc = sat(mrc, cmax(d));
      c.ewc = mewc; c.eoob = meoob;
      cq[d].push_back(c);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    cexp_t c;
    rst_n = 1'b0; wr_en = '0; rd_en = '0;
    for (int q = 0; q < 4; q++) rq[q].delete();
    for (int d = 0; d < 2; d++) cq[d].delete();
    mwc = 0; mrc = 0; mewc = 1'b0; meoob = 1'b0;
    for (int d = 0; d < 2; d++) begin
      c.due = cyc; c.rst = 1'b1; c.wc = 0; c.rc = 0; c.ewc = 1'b0; c.eoob = 1'b0;
      cq[d].push_back(c);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0;
    for (int w = 0; w < 6; w++) begin mknown[w] = 1'b0; mmem[w] = '0; end
    mwc = 0; mrc = 0; mewc = 1'b0; meoob = 1'b0;
    @(posedge clk); #1;
    do_reset();

    step(2'b01, 3, 0, 32'hA5A5_0001, 0, 2'b00, 0, 0);
    step(2'b00, 0, 0, 0, 0, 2'b10, 0, 3);
    step(2'b01, 5, 0, 32'h22, 0, 2'b00, 0, 0);
    step(2'b01, 5, 0, 32'h11, 0, 2'b01, 5, 0);
    step(2'b11, 2, 2, 32'hAA, 32'hBB, 2'b00, 0, 0);
    step(2'b00, 0, 0, 0, 0, 2'b11, 2, 5);
    step(2'b01, 7, 0, 32'hDEAD, 0, 2'b01, 6, 0);
    step(2'b00, 0, 0, 0, 0, 2'b11, 3, 2);
    for (int w = 0; w < 6; w += 2) step(2'b11, w, w + 1, $urandom, $urandom, 2'b00, 0, 0);
    for (int i = 0; i < 8; i++) step(2'b00, 0, 0, 0, 0, 2'b11, i % 6, (i + 3) % 6);

    step(2'b00, 0, 0, 0, 0, 2'b11, 1, 4);
    step(2'b00, 0, 0, 0, 0, 2'b11, 0, 5);
    do_reset();
    step(2'b00, 0, 0, 0, 0, 2'b11, 3, 2);
    for (int i = 0; i < 9; i++) step(2'b01, i % 6, 0, $urandom, 0, 2'b00, 0, 0);
    step(2'b00, 0, 0, 0, 0, 2'b11, 0, 1);

    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom, $urandom,
                2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 7));
    end
    repeat (4) step(2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    @(negedge clk); #1;
    for (int q = 0; q < 4; q++) check("rd_leftover", q / 2, 64'(rq[q].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
